// File: rtl/note_sequencer.sv
// Melody sequencer: plays up to DEPTH {period, dur, rest} entries into a square-wave tone generator.
// States: IDLE wait for start | LOAD fetch entry | PLAY note sounding | GAP inter-note silence | DONE completion pulse
module note_sequencer #(
  parameter int DEPTH     = 16,
  parameter int TICK_DIV  = 48000,
  parameter int GAP_TICKS = 10,
  localparam int IW       = $clog2(DEPTH),
  localparam int PW       = $clog2(TICK_DIV)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wr_en_i,
  input  logic [IW-1:0] wr_addr_i,
  input  logic [25:0]   wr_period_i,
  input  logic [15:0]   wr_dur_i,
  input  logic          wr_rest_i,
  input  logic [IW-1:0] seq_last_i,
  input  logic          loop_i,
  input  logic          start_i,
  input  logic          stop_i,
  output logic [25:0]   period_o,
  output logic          en_o,
  output logic          busy_o,
  output logic          done_o,
  output logic [IW-1:0] cur_idx_o
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [42:0]   mem_q [DEPTH];
  logic [25:0]   period_q, period_d;
  logic          en_q, en_d;
  logic          note_on_q, note_on_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] last_q, last_d;
  logic [15:0]   dur_q, dur_d;
  logic [PW-1:0] pre_q, pre_d;

  logic [42:0]   rd_entry;
  logic [25:0]   rd_period;
  logic [15:0]   rd_dur;
  logic          rd_rest;
  logic          tick;
  logic          advance;
  logic [IW-1:0] seq_last_sat;

  // Entry storage is deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= {wr_period_i, wr_dur_i, wr_rest_i};
  end

  assign rd_entry     = mem_q[idx_q];
  assign rd_period    = rd_entry[42:17];
  assign rd_dur       = rd_entry[16:1];
  assign rd_rest      = rd_entry[0];
  assign tick         = (pre_q == PW'(TICK_DIV - 1));
  assign seq_last_sat = (int'(seq_last_i) > DEPTH - 1) ? IW'(DEPTH - 1) : seq_last_i;

  always_comb begin
    state_d   = state_q;
    period_d  = period_q;
    note_on_d = note_on_q;
    idx_d     = idx_q;
    last_d    = last_q;
    dur_d     = dur_q;
    pre_d     = pre_q;
    advance   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i && !stop_i) begin
          state_d = S_LOAD;
          idx_d   = '0;
          last_d  = seq_last_sat;
        end
      end
      S_LOAD: begin
        period_d  = rd_period;
        dur_d     = rd_dur;
        pre_d     = '0;
        note_on_d = !rd_rest && (rd_period != 26'd0);
        if (rd_dur == 16'd0) advance = 1'b1;
        else                 state_d = S_PLAY;
      end
      S_PLAY, S_GAP: begin
        pre_d = tick ? '0 : pre_q + PW'(1);
        if (tick) begin
          dur_d = dur_q - 16'd1;
          // The duration counter is reused to time the gap.
          if (dur_q == 16'd1) begin
            if (state_q == S_PLAY && GAP_TICKS > 0) begin
              state_d = S_GAP;
              dur_d   = 16'(GAP_TICKS);
            end else begin
              advance = 1'b1;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (advance) begin
      if (idx_q == last_q) begin
        if (loop_i) begin
          idx_d   = '0;
          state_d = S_LOAD;
        end else begin
          state_d = S_DONE;
        end
      end else begin
        idx_d   = idx_q + IW'(1);
        state_d = S_LOAD;
      end
    end

    if (stop_i && state_q != S_IDLE) state_d = S_IDLE;

    en_d = (state_d == S_PLAY) && note_on_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      period_q  <= '0;
      en_q      <= 1'b0;
      note_on_q <= 1'b0;
      idx_q     <= '0;
      last_q    <= '0;
      dur_q     <= '0;
      pre_q     <= '0;
    end else begin
      state_q   <= state_d;
      period_q  <= period_d;
      en_q      <= en_d;
      note_on_q <= note_on_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      dur_q     <= dur_d;
      pre_q     <= pre_d;
    end
  end

  assign period_o  = period_q;
  assign en_o      = en_q;
  assign busy_o    = (state_q != S_IDLE);
  assign done_o    = (state_q == S_DONE);
  assign cur_idx_o = idx_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: a note-list model expands each sequence into a per-cycle
// trace of {busy, done, en, period, cur_idx} that is compared against the DUT.
module tb_note_sequencer;
  localparam int TD = 4;
  localparam int GT = 1;
  localparam int L1 = 1 + TD + GT * TD;

  logic        clk = 1'b0;
  logic        rst, wr_en, wr_rest, loop, start, stop;
  logic [3:0]  wr_addr, seq_last;
  logic [25:0] wr_period;
  logic [15:0] wr_dur;
  logic [25:0] period;
  logic        en, busy, done;
  logic [3:0]  cur_idx;

  always #5 clk = ~clk;

  note_sequencer #(.DEPTH(16), .TICK_DIV(TD), .GAP_TICKS(GT)) dut (
    .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
    .wr_period_i(wr_period), .wr_dur_i(wr_dur), .wr_rest_i(wr_rest),
    .seq_last_i(seq_last), .loop_i(loop), .start_i(start), .stop_i(stop),
    .period_o(period), .en_o(en), .busy_o(busy), .done_o(done), .cur_idx_o(cur_idx)
  );

  int          checks = 0;
  int          failures = 0;
  logic [25:0] m_per [16];
  logic [15:0] m_dur [16];
  logic        m_rest [16];
  logic [25:0] cur_p;
  logic [32:0] exp_q [$];

  function automatic logic [32:0] pack(input logic b, input logic d, input logic e,
                                       input logic [25:0] p, input logic [3:0] i);
    return {b, d, e, p, i};
  endfunction

  task automatic push_n(input logic [32:0] v, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(v);
  endtask

  // One entry: a LOAD cycle still showing the old period, then note and gap if dur is nonzero.
  task automatic model_entry(input int i);
    push_n(pack(1'b1, 1'b0, 1'b0, cur_p, 4'(i)), 1);
    cur_p = m_per[i];
    if (m_dur[i] != 16'd0) begin
      push_n(pack(1'b1, 1'b0, !m_rest[i] && (cur_p != 26'd0), cur_p, 4'(i)), int'(m_dur[i]) * TD);
      push_n(pack(1'b1, 1'b0, 1'b0, cur_p, 4'(i)), GT * TD);
    end
  endtask

  task automatic model_finish(input int last);
    push_n(pack(1'b1, 1'b1, 1'b0, cur_p, 4'(last)), 1);
    push_n(pack(1'b0, 1'b0, 1'b0, cur_p, 4'(last)), 1);
  endtask

  task automatic model_seq(input int last);
    for (int i = 0; i <= last; i++) model_entry(i);
    model_finish(last);
  endtask

  task automatic chk(input logic [32:0] obs, input logic [32:0] expv, input string tag, input int cyc);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s cycle %0d: observed {busy,done,en,period,idx}=%h required %h", tag, cyc, obs, expv);
    end
  endtask

  task automatic run_q(input int n, input string tag);
    int cnt;
    cnt = (n < 0) ? exp_q.size() : n;
    for (int k = 0; k < cnt; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL %s cycle %0d: observed trace longer than model, required end of trace", tag, k);
      end else begin
        chk({busy, done, en, period, cur_idx}, exp_q.pop_front(), tag, k);
      end
    end
  endtask

  task automatic wr(input int a, input logic [25:0] p, input logic [15:0] d, input logic r);
    wr_en = 1'b1; wr_addr = 4'(a); wr_period = p; wr_dur = d; wr_rest = r;
    @(negedge clk);
    wr_en = 1'b0;
    m_per[a] = p; m_dur[a] = d; m_rest[a] = r;
  endtask

  task automatic pulse_start(input string tag);
    start = 1'b1;
    run_q(1, tag);
    start = 1'b0;
  endtask

  initial begin
    int last;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_period = '0; wr_dur = '0; wr_rest = 1'b0;
    seq_last = '0; loop = 1'b0; start = 1'b0; stop = 1'b0;
    cur_p = '0;
    repeat (3) @(negedge clk);
    chk({busy, done, en, period, cur_idx}, 33'd0, "reset", 0);
    rst = 1'b0;

    // Basic two-note sequence
    wr(0, 26'd100, 16'd2, 1'b0);
    wr(1, 26'd200, 16'd1, 1'b0);
    seq_last = 4'd1; loop = 1'b0;
    model_seq(1);
    pulse_start("basic");
    run_q(-1, "basic");

    // Rest entry and zero-duration skip
    wr(0, 26'd100, 16'd1, 1'b1);
    wr(1, 26'd300, 16'd0, 1'b0);
    wr(2, 26'd50,  16'd1, 1'b0);
    seq_last = 4'd2;
    model_seq(2);
    pulse_start("rest_skip");
    run_q(-1, "rest_skip");

    // Loop on a single entry, then release the loop
    wr(0, 26'd100, 16'd1, 1'b0);
    seq_last = 4'd0; loop = 1'b1;
    for (int it = 0; it < 4; it++) model_entry(0);
    model_finish(0);
    pulse_start("loop");
    run_q(L1 - 1 + 2 * L1 + 1, "loop");
    loop = 1'b0;
    run_q(-1, "loop_end");

    // start together with stop while idle stays idle
    start = 1'b1; stop = 1'b1;
    push_n(pack(1'b0, 1'b0, 1'b0, cur_p, 4'd0), 1);
    run_q(1, "start_stop_idle");
    start = 1'b0; stop = 1'b0;

    // Stop three cycles into PLAY, then replay from entry 0
    wr(0, 26'd100, 16'd2, 1'b0);
    seq_last = 4'd0;
    push_n(pack(1'b1, 1'b0, 1'b0, cur_p, 4'd0), 1);
    cur_p = 26'd100;
    push_n(pack(1'b1, 1'b0, 1'b1, cur_p, 4'd0), 3);
    push_n(pack(1'b0, 1'b0, 1'b0, cur_p, 4'd0), 2);
    pulse_start("stop");
    run_q(3, "stop");
    stop = 1'b1;
    run_q(1, "stop_idle");
    stop = 1'b0;
    run_q(1, "stop_idle");
    model_seq(0);
    pulse_start("replay");
    run_q(-1, "replay");

    // start while busy is ignored; reset during GAP clears everything
    wr(0, 26'd100, 16'd1, 1'b0);
    wr(1, 26'd200, 16'd1, 1'b0);
    seq_last = 4'd1;
    model_entry(0);
    pulse_start("busy_start");
    run_q(2, "busy_start");
    start = 1'b1;
    run_q(1, "busy_start");
    start = 1'b0;
    run_q(3, "busy_start");
    exp_q.delete();
    rst = 1'b1;
    cur_p = '0;
    push_n(33'd0, 1);
    run_q(1, "reset_mid");
    rst = 1'b0;

    // Rewrite the playing entry; the write coincides with its LOAD
    wr(0, 26'd100, 16'd1, 1'b0);
    seq_last = 4'd0; loop = 1'b1;
    push_n(pack(1'b1, 1'b0, 1'b0, cur_p, 4'd0), 1);
    push_n(pack(1'b1, 1'b0, 1'b1, 26'd100, 4'd0), TD);
    push_n(pack(1'b1, 1'b0, 1'b0, 26'd100, 4'd0), GT * TD + 1);
    push_n(pack(1'b1, 1'b0, 1'b1, 26'd777, 4'd0), TD);
    push_n(pack(1'b0, 1'b0, 1'b0, 26'd777, 4'd0), 1);
    pulse_start("rewrite");
    wr_en = 1'b1; wr_addr = 4'd0; wr_period = 26'd777; wr_dur = 16'd1; wr_rest = 1'b0;
    run_q(1, "rewrite");
    wr_en = 1'b0;
    m_per[0] = 26'd777;
    run_q(TD - 1 + GT * TD + 1 + TD, "rewrite");
    stop = 1'b1;
    run_q(1, "rewrite_stop");
    stop = 1'b0; loop = 1'b0;
    cur_p = 26'd777;

    // Random note lists against the model
    for (int r = 0; r < 4; r++) begin
      last = $urandom_range(0, 5);
      for (int i = 0; i <= last; i++)
        wr(i, ($urandom_range(0, 3) == 0) ? 26'd0 : 26'($urandom),
           16'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
      seq_last = 4'(last);
      model_seq(last);
      pulse_start("random");
      run_q(-1, "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/note_sequencer.md
# note_sequencer

Programmable melody sequencer that drives the square-wave tone generator's `period` and `en` inputs. A host loads up to 16 note entries (period, duration, rest flag) and issues `start`; the block then plays them in order, counting durations in millisecond ticks derived from the 48 MHz `clk`. It sits between control logic and the tone generator and owns all timing of note on/off.

## Interface
- `DEPTH`, 16: number of note entries; `wr_addr`, `cur_idx` and `seq_last` are log2(DEPTH) bits wide.
- `TICK_DIV`, 48000: `clk` cycles per duration tick; 1 ms at 48 MHz. Must be ≥ 2.
- `GAP_TICKS`, 10: silent ticks inserted after each note. 0 means no gap.

- `clk`  in  1  system clock, 48 MHz.
- `rst`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  write one note entry this cycle.
- `wr_addr`  in  4  entry index to write.
- `wr_period`  in  26  tone period in `clk` cycles; passed unchanged to the tone generator.
- `wr_dur`  in  16  note duration in ticks.
- `wr_rest`  in  1  1 = silent entry: `en` stays 0 for the duration.
- `seq_last`  in  4  index of the last entry to play; captured on `start`.
- `loop`  in  1  1 = after the last entry, restart at entry 0; sampled at each wrap.
- `start`  in  1  begin playback from entry 0; ignored while `busy`.
- `stop`  in  1  abort playback; takes priority over `start`.
- `period`  out  26  period to the tone generator; registered.
- `en`  out  1  tone enable to the tone generator; registered.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse on natural completion.
- `cur_idx`  out  4  index of the entry being played.

## Operation
- **Storage:** DEPTH × 43-bit register file holding {period, dur, rest}.
  - Not cleared by reset.
  - Writes are accepted in any state.
  - Entry fields are latched only in LOAD, so rewriting the playing entry affects only its next load.
- **States:** IDLE, LOAD, PLAY, GAP, DONE.
- **IDLE:** `en`=0, `busy`=0. On `start` (and no `stop`): capture `seq_last`, set `cur_idx`=0, go to LOAD.
- **LOAD** (one cycle, `en`=0):
  - `period` ← entry period; duration counter ← entry dur; prescaler cleared.
  - If dur==0, skip the entry: advance immediately, with no PLAY and no GAP.
  - Otherwise go to PLAY.
- **PLAY:**
  - `en` = !rest && period!=0.
  - The prescaler counts 0..TICK_DIV-1 and emits a tick on TICK_DIV-1, then wraps to 0.
  - Each tick decrements the duration counter. The tick that takes it to 0 exits PLAY:
    - to GAP if GAP_TICKS>0, otherwise advance.
- **GAP:** `en`=0 and `period` is held. After GAP_TICKS ticks, advance.
- **Advance:**
  - If `cur_idx`==captured last and `loop`=1: `cur_idx`←0, go to LOAD.
  - If `cur_idx`==captured last and `loop`=0: go to DONE.
  - Otherwise: `cur_idx`+1, go to LOAD.
- **DONE:** one cycle with `done`=1 and `en`=0, then IDLE.
- **Stop:** `stop` in any non-IDLE state → IDLE next cycle.
  - `en`=0, no `done` pulse, `period` retains its last value.
- **Arithmetic:** prescaler is ceil(log2(TICK_DIV)) bits; duration counter is 16 bits; no wrap-around is possible.
- A `seq_last` greater than DEPTH-1 is saturated to DEPTH-1 at capture.

## Timing
- **Reset:**
  - state=IDLE; `period`=0, `en`=0, `busy`=0, `done`=0, `cur_idx`=0.
  - Prescaler and duration counter cleared.
  - Reset mid-playback behaves like `stop`, and also clears `period`.
- **Start latency:** `start` sampled at edge N → LOAD (`busy`=1) from N+1 → PLAY with valid `en`/`period` from N+2.
- **Per-entry timeline:**
  - `en` high for exactly dur×TICK_DIV cycles.
  - Then low for GAP_TICKS×TICK_DIV cycles (GAP) plus 1 cycle (next LOAD).
- **Looping:** the wrap costs one LOAD cycle, the same as any other advance.
- **Completion:** `done` asserts the cycle after the last GAP (or PLAY) ends. `busy` drops the cycle after `done`.
- **Simultaneous events:**
  - `start`+`stop` in IDLE: stay in IDLE.
  - A write to the entry being loaded in the same cycle: LOAD sees the old contents (write-after-read).

## Test plan
Bench parameters: TICK_DIV=4, GAP_TICKS=1.

1. **Basic sequence.**
   - Stimulus: write e0={100,2,0}, e1={200,1,0}; `seq_last`=1, `loop`=0; pulse `start`.
   - Required: `en`=1, `period`=100 for 8 cycles; 5 cycles `en`=0; `en`=1, `period`=200 for 4 cycles; 4 cycles `en`=0; then `done` for 1 cycle; `busy` low the next cycle.
2. **Rest and zero-duration skip.**
   - Stimulus: e0={100,1,1}, e1={300,0,0}, e2={50,1,0}; `seq_last`=2.
   - Required: e0 keeps `en`=0 for 4+4 cycles; e1 occupies one LOAD cycle only; e2 gives `en`=1 for 4 cycles.
3. **Loop.**
   - Stimulus: `loop`=1, `seq_last`=0, e0={100,1,0}.
   - Required: `en` period-9 pattern (4 high / 5 low) repeats with `cur_idx`=0 and no `done`; after `loop`←0, `done` follows the next gap.
4. **Stop mid-note.**
   - Stimulus: assert `stop` 3 cycles into PLAY.
   - Required: next cycle `en`=0, `busy`=0, no `done`; a subsequent `start` replays from entry 0.
5. **Reset mid-playback and ignored start.**
   - Stimulus: `start` pulsed while `busy`; later `rst` during GAP.
   - Required: the `start` has no effect on `cur_idx`; after `rst` every output is 0 on the next cycle.
6. **Write during play.**
   - Stimulus: rewrite e0 to period 777 while e0 plays with `loop`=1.
   - Required: current note keeps `period`=100; the next iteration shows 777.
